// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg : shared encodings for the core SRAM arbiter       rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  // Wide enough for MAX_STREAK up to 15 and RD_LAT up to 7.
  localparam int STREAK_W = 4;
  localparam int WAIT_W   = 3;

endpackage

`default_nettype wire

// File: rtl/sram_arb_prio.sv
// ---------------------------------------------------------------------------
// sram_arb_prio : LSU-first grant decision with IFU anti-starvation  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_arb_prio
  import sram_arb_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ifu_req,
  input  logic lsu_req,
  input  logic idle,
  output logic gnt_sel
);

  logic [STREAK_W-1:0] r_streak;
  logic                w_streak_full;

  assign w_streak_full = (r_streak == STREAK_W'(MAX_STREAK));

  always_comb begin
    gnt_sel = GNT_IFU;
    if (lsu_req && (!ifu_req || !w_streak_full))
      gnt_sel = GNT_LSU;
  end

  // Streak only counts LSU wins that actually made the IFU wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (idle) begin
      if (!ifu_req || gnt_sel == GNT_IFU)
        r_streak <= '0;
      else if (!w_streak_full)
        r_streak <= r_streak + STREAK_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_arb_ctrl.sv
// ---------------------------------------------------------------------------
// sram_arb_ctrl : IFU/LSU sequencer for the single-port core SRAM  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_arb_ctrl
  import sram_arb_pkg::*;
#(
  parameter int AW         = 14,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ifu_req,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_ack,
  output logic [DW-1:0]   ifu_rdata,
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_be,
  output logic            lsu_ack,
  output logic [DW-1:0]   lsu_rdata,
  output logic            sram_en,
  output logic            sram_we,
  output logic [AW-1:0]   sram_addr,
  output logic [DW-1:0]   sram_wdata,
  output logic [DW/8-1:0] sram_be,
  input  logic [DW-1:0]   sram_rdata,
  output logic            busy
);

  state_t            r_state;
  state_t            w_next;
  logic              r_gnt;
  logic              r_is_write;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              w_gnt;
  logic              w_idle;
  logic              w_start;
  logic              w_last_wait;

  assign w_idle      = (r_state == IDLE);
  assign w_start     = w_idle && (ifu_req || lsu_req);
  assign w_last_wait = (r_state == WAIT) && (r_wait_cnt == WAIT_W'(RD_LAT - 1));

  sram_arb_prio #(
    .MAX_STREAK (MAX_STREAK)
  ) u_prio (
    .clk     (clk),
    .rst_n   (rst_n),
    .ifu_req (ifu_req),
    .lsu_req (lsu_req),
    .idle    (w_idle),
    .gnt_sel (w_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = ISSUE;
      ISSUE:   w_next = r_is_write ? ACK : WAIT;
      WAIT:    if (w_last_wait) w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Every output is registered off the next state so it lines up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt      <= GNT_IFU;
      r_is_write <= 1'b0;
      r_wait_cnt <= '0;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_be    <= '0;
      ifu_ack    <= 1'b0;
      lsu_ack    <= 1'b0;
      ifu_rdata  <= '0;
      lsu_rdata  <= '0;
      busy       <= 1'b0;
    end else begin
      sram_en <= w_start;
      sram_we <= w_start && (w_gnt == GNT_LSU) && lsu_we;
      if (w_start) begin
        r_gnt      <= w_gnt;
        r_is_write <= (w_gnt == GNT_LSU) && lsu_we;
        if (w_gnt == GNT_LSU) begin
          sram_addr  <= lsu_addr;
          sram_wdata <= lsu_wdata;
          sram_be    <= lsu_be;
        end else begin
          sram_addr  <= ifu_addr;
          sram_be    <= '1;
        end
      end

      if (r_state == WAIT) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      else                 r_wait_cnt <= '0;

      if (w_last_wait) begin
        if (r_gnt == GNT_LSU) lsu_rdata <= sram_rdata;
        else                  ifu_rdata <= sram_rdata;
      end

      ifu_ack <= (w_next == ACK) && (r_gnt == GNT_IFU);
      lsu_ack <= (w_next == ACK) && (r_gnt == GNT_LSU);
      busy    <= (w_next != IDLE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_arb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_arb_ctrl : directed bench for sram_arb_ctrl (RD_LAT 1 and 3) rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram_arb_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: RD_LAT=1
  logic        ifu_req = 0, lsu_req = 0, lsu_we = 0;
  logic [13:0] ifu_addr = '0, lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_be = '0;
  logic        ifu_ack, lsu_ack, sram_en, sram_we, busy;
  logic [31:0] ifu_rdata, lsu_rdata, sram_wdata, sram_rdata;
  logic [13:0] sram_addr;
  logic [3:0]  sram_be;

  // Instance B: RD_LAT=3
  logic        b_ifu_req = 0, b_lsu_req = 0, b_lsu_we = 0;
  logic [13:0] b_ifu_addr = '0, b_lsu_addr = '0;
  logic [31:0] b_lsu_wdata = '0;
  logic [3:0]  b_lsu_be = '0;
  logic        b_ifu_ack, b_lsu_ack, b_sram_en, b_sram_we, b_busy;
  logic [31:0] b_ifu_rdata, b_lsu_rdata, b_sram_wdata;
  logic [13:0] b_sram_addr;
  logic [3:0]  b_sram_be;

  sram_arb_ctrl #(.AW(14), .DW(32), .RD_LAT(1), .MAX_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_ack(ifu_ack), .ifu_rdata(ifu_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_be(lsu_be), .lsu_ack(lsu_ack), .lsu_rdata(lsu_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_be(sram_be), .sram_rdata(sram_rdata), .busy(busy)
  );

  logic [31:0] b_pipe [0:2];

  sram_arb_ctrl #(.AW(14), .DW(32), .RD_LAT(3), .MAX_STREAK(4)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .ifu_req(b_ifu_req), .ifu_addr(b_ifu_addr), .ifu_ack(b_ifu_ack), .ifu_rdata(b_ifu_rdata),
    .lsu_req(b_lsu_req), .lsu_we(b_lsu_we), .lsu_addr(b_lsu_addr), .lsu_wdata(b_lsu_wdata),
    .lsu_be(b_lsu_be), .lsu_ack(b_lsu_ack), .lsu_rdata(b_lsu_rdata),
    .sram_en(b_sram_en), .sram_we(b_sram_we), .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata),
    .sram_be(b_sram_be), .sram_rdata(b_pipe[2]), .busy(b_busy)
  );

  // SRAM models: read data appears exactly RD_LAT edges after the strobe,
  // with a poison value on every other cycle.
  logic [31:0] mem_a [0:16383];
  logic [31:0] mem_b [0:16383];

  always @(posedge clk) begin
    if (!rst_n) begin
      mem_a[14'h0010] <= 32'hDEADBEEF;
      mem_a[14'h0020] <= 32'hAABBCCDD;
      mem_a[14'h0040] <= 32'h11223344;
    end else if (sram_en && sram_we) begin
      for (int b = 0; b < 4; b++)
        if (sram_be[b]) mem_a[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
    sram_rdata <= (sram_en && !sram_we) ? mem_a[sram_addr] : 32'hBADBAD00;
  end

  always @(posedge clk) begin
    if (!rst_n) mem_b[14'h0030] <= 32'hCAFEF00D;
    else if (b_sram_en && b_sram_we) mem_b[b_sram_addr] <= b_sram_wdata;
    b_pipe[0] <= (b_sram_en && !b_sram_we) ? mem_b[b_sram_addr] : 32'hBADBAD00;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end

  int en_cnt = 0, lsu_ack_cnt = 0;
  always @(posedge clk) begin
    if (sram_en) en_cnt <= en_cnt + 1;
    if (lsu_ack) lsu_ack_cnt <= lsu_ack_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for an ack on instance A; n counts edges from the request edge.
  task automatic wait_ack(input bit lsu, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(lsu ? lsu_ack : ifu_ack) && n < 30);
  endtask

  task automatic lsu_txn(input string tag, input bit we, input logic [13:0] addr,
                         input logic [31:0] wd, input logic [3:0] be,
                         input int exp_lat, input logic [31:0] exp_rd);
    int n;
    lsu_we = we; lsu_addr = addr; lsu_wdata = wd; lsu_be = be; lsu_req = 1'b1;
    wait_ack(1'b1, n);
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_ifu_ack"}, {31'd0, ifu_ack}, 32'd0);
    if (!we) check({tag, "_rdata"}, lsu_rdata, exp_rd);
    lsu_req = 1'b0;
    tick();
    check({tag, "_ack_pulse"}, {31'd0, lsu_ack}, 32'd0);
  endtask

  initial begin
    int n, k, cyc, en0, ack0;
    logic [9:0] gseq;
    logic both;

    // Reset state
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_en_we", {30'd0, sram_en, sram_we}, 32'd0);
    check("rst_acks", {30'd0, ifu_ack, lsu_ack}, 32'd0);
    check("rst_addr", {18'd0, sram_addr}, 32'd0);
    check("rst_wdata_be", sram_wdata | {28'd0, sram_be}, 32'd0);
    check("rst_rdata", ifu_rdata | lsu_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // IFU read alone, RD_LAT=1
    en0 = en_cnt;
    ifu_addr = 14'h0010; ifu_req = 1'b1;
    tick();
    check("ifu_issue_en", {31'd0, sram_en}, 32'd1);
    check("ifu_issue_we", {31'd0, sram_we}, 32'd0);
    check("ifu_issue_addr", {18'd0, sram_addr}, 32'h10);
    check("ifu_issue_be", {28'd0, sram_be}, 32'hF);
    check("ifu_busy", {31'd0, busy}, 32'd1);
    tick();
    check("ifu_en_drop", {31'd0, sram_en}, 32'd0);
    check("ifu_ack_early", {31'd0, ifu_ack}, 32'd0);
    tick();
    check("ifu_ack_lat3", {31'd0, ifu_ack}, 32'd1);
    check("ifu_rdata", ifu_rdata, 32'hDEADBEEF);
    check("ifu_no_lsu_ack", {31'd0, lsu_ack}, 32'd0);
    ifu_req = 1'b0;
    tick();
    check("ifu_ack_pulse", {31'd0, ifu_ack}, 32'd0);
    check("ifu_idle", {31'd0, busy}, 32'd0);
    check("ifu_en_cycles", en_cnt - en0, 32'd1);

    // LSU partial write, then read back the merged word
    lsu_we = 1'b1; lsu_addr = 14'h0020; lsu_wdata = 32'h12345678; lsu_be = 4'b0011;
    lsu_req = 1'b1;
    tick();
    check("wr_en", {30'd0, sram_en, sram_we}, 32'd3);
    check("wr_be", {28'd0, sram_be}, 32'h3);
    check("wr_addr", {18'd0, sram_addr}, 32'h20);
    check("wr_wdata", sram_wdata, 32'h12345678);
    tick();
    check("wr_ack_lat2", {31'd0, lsu_ack}, 32'd1);
    lsu_req = 1'b0;
    tick();
    check("wr_ack_pulse", {31'd0, lsu_ack}, 32'd0);
    lsu_txn("rd_merged", 1'b0, 14'h0020, 32'h0, 4'h0, 3, 32'hAABB5678);
    check("ifu_rdata_hold", ifu_rdata, 32'hDEADBEEF);

    // Contention: LSU streak limited to 4
    lsu_we = 1'b0; lsu_addr = 14'h0020; ifu_addr = 14'h0010;
    ifu_req = 1'b1; lsu_req = 1'b1;
    gseq = '0; k = 0; cyc = 0; both = 1'b0;
    while (k < 10 && cyc < 300) begin
      tick();
      cyc++;
      if (ifu_ack && lsu_ack) both = 1'b1;
      if (lsu_ack) begin gseq[k] = 1'b1; k++; end
      else if (ifu_ack) begin gseq[k] = 1'b0; k++; end
    end
    ifu_req = 1'b0; lsu_req = 1'b0;
    check("arb_count", k, 32'd10);
    check("arb_seq", {22'd0, gseq}, {22'd0, 10'b0111101111});
    check("arb_both_ack", {31'd0, both}, 32'd0);
    tick();

    // RD_LAT=3 LSU read on the second instance
    b_lsu_we = 1'b0; b_lsu_addr = 14'h0030; b_lsu_req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!b_lsu_ack && n < 30);
    check("lat3_ack", n, 32'd5);
    check("lat3_rdata", b_lsu_rdata, 32'hCAFEF00D);
    check("lat3_no_ifu_ack", {31'd0, b_ifu_ack}, 32'd0);
    b_lsu_req = 1'b0;
    tick();
    check("lat3_idle", {31'd0, b_busy}, 32'd0);

    // Reset during WAIT, then the held request completes
    ifu_addr = 14'h0040; ifu_req = 1'b1;
    tick();
    tick();
    check("rstw_in_wait", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstw_busy", {31'd0, busy}, 32'd0);
    check("rstw_en", {31'd0, sram_en}, 32'd0);
    check("rstw_ack", {30'd0, ifu_ack, lsu_ack}, 32'd0);
    check("rstw_rdata", ifu_rdata, 32'd0);
    tick();
    tick();
    check("rstw_no_ack", {31'd0, ifu_ack}, 32'd0);
    rst_n = 1'b1;
    wait_ack(1'b0, n);
    check("rstw_retry_lat", n, 32'd3);
    check("rstw_retry_rdata", ifu_rdata, 32'h11223344);
    ifu_req = 1'b0;
    tick();

    // New request presented in the cycle after ack
    ack0 = lsu_ack_cnt;
    lsu_we = 1'b1; lsu_addr = 14'h0050; lsu_wdata = 32'hA5A5A5A5; lsu_be = 4'hF;
    lsu_req = 1'b1;
    wait_ack(1'b1, n);
    check("b2b_wr_lat", n, 32'd2);
    tick();
    check("b2b_gap_ack", {31'd0, lsu_ack}, 32'd0);
    check("b2b_gap_busy", {31'd0, busy}, 32'd0);
    lsu_we = 1'b0;
    wait_ack(1'b1, n);
    check("b2b_rd_lat", n, 32'd3);
    check("b2b_rd_data", lsu_rdata, 32'hA5A5A5A5);
    lsu_req = 1'b0;
    repeat (4) tick();
    check("b2b_ack_total", lsu_ack_cnt - ack0, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_arb_ctrl.md
Name: sram_arb_ctrl

Overview:
- Sequences and shares the single-port core SRAM between the instruction-fetch unit (IFU) and the load/store unit (LSU).
- Runs on the fast `clk` domain that also drives SRAM timing.
- Converts per-requester req/ack handshakes into SRAM enable, write, address and byte-enable cycles, honouring a fixed SRAM read latency.
- LSU has fixed priority; a streak limiter stops it starving the IFU.

Parameters:
- AW, 14: SRAM word-address width.
- DW, 32: data width, a multiple of 8.
- RD_LAT, 1: cycles from the sram_en capture edge until sram_rdata is valid. Range 1..7.
- MAX_STREAK, 4: maximum consecutive LSU grants while IFU is waiting. Range 1..15.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ifu_req  in  1  IFU read request; held with ifu_addr stable until ifu_ack
- ifu_addr  in  AW  IFU word address
- ifu_ack  out  1  one-cycle pulse; ifu_rdata valid in the same cycle
- ifu_rdata  out  DW  IFU read data
- lsu_req  in  1  LSU request; held with its address, data and controls stable until lsu_ack
- lsu_we  in  1  1 = write, 0 = read
- lsu_addr  in  AW  LSU word address
- lsu_wdata  in  DW  LSU write data
- lsu_be  in  DW/8  LSU byte enables; write only
- lsu_ack  out  1  one-cycle pulse; lsu_rdata valid in the same cycle on reads
- lsu_rdata  out  DW  LSU read data
- sram_en  out  1  SRAM access strobe
- sram_we  out  1  SRAM write
- sram_addr  out  AW  SRAM address
- sram_wdata  out  DW  SRAM write data
- sram_be  out  DW/8  SRAM byte enables
- sram_rdata  in  DW  SRAM read data
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- All outputs are registered.
- Reset values:
  - all acks, sram_en, sram_we and busy are 0.
  - addresses, data and be are 0.
  - state is IDLE; streak counter and wait counter are 0.
- States:
  - IDLE: sample requests and pick a grant.
  - ISSUE: exactly 1 cycle; sram_en=1, and sram_we/addr/wdata/be are driven from the granted requester.
  - WAIT: RD_LAT cycles; reads only.
  - ACK: exactly 1 cycle; the granted ack is 1.
- Transitions:
  - IDLE→ISSUE when any request is high at the edge.
  - ISSUE→ACK for writes.
  - ISSUE→WAIT for reads.
  - WAIT→ACK when the wait counter reaches RD_LAT-1. sram_rdata is captured into the granted rdata register at that edge.
  - ACK→IDLE always.
- Latency, with the request sampled at edge E0:
  - write: ack is high in the cycle after E1, i.e. 2 cycles after E0.
  - read: ack is high RD_LAT+2 cycles after E0.
- Outside ISSUE, sram_en=0 and sram_we=0. The address and data outputs hold their last values.
- IFU accesses always drive sram_we=0 and sram_be all-ones.
- Handshake:
  - A requester drops req, or presents a new request, in the cycle after its ack.
  - A req high in IDLE is always a new request, so back-to-back requests are allowed with 1 idle cycle between acks.
  - Requests that arrive while busy stay pending; they are never lost and never double-served.
- Arbitration in IDLE:
  - Only IFU requesting: grant IFU.
  - Only LSU requesting: grant LSU.
  - Both requesting: grant LSU unless streak == MAX_STREAK, in which case grant IFU.
- Streak counter:
  - increments on an LSU grant made while ifu_req is high; saturates at MAX_STREAK.
  - clears on any IFU grant, and on any IDLE cycle where ifu_req is low.
- rdata of the non-granted requester holds its previous value.
- The ack of the non-granted requester is never asserted.
- Reset mid-operation: return immediately to reset values. The in-flight access is abandoned without an ack, and the requester must reissue. A write already strobed may have landed in the SRAM.

Decomposition:
- Package sram_arb_pkg contains:
  - state encoding localparams: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, ACK=2'd3.
  - grant encoding: GNT_IFU=1'b0, GNT_LSU=1'b1.
  - the streak counter width.
- One sub-module, sram_arb_prio: the combinational grant decision plus the streak counter register. Its inputs are ifu_req, lsu_req and an idle flag; its output is a grant select.
- The FSM, wait counter and output registers stay in sram_arb_ctrl.

Test Plan:
- IFU read alone, addr=0x0010, SRAM model returns 0xDEADBEEF with RD_LAT=1 -> sram_en high for exactly 1 cycle with sram_addr=0x0010 and sram_we=0; ifu_ack pulses 3 cycles after the request edge with ifu_rdata=0xDEADBEEF.
- LSU write addr=0x0020, wdata=0x12345678, be=4'b0011 -> one sram_en cycle with sram_we=1 and sram_be=0011; lsu_ack 2 cycles after the request; a subsequent LSU read of 0x0020 returns the model's merged word.
- IFU and LSU requesting together, LSU issuing continuous reads, MAX_STREAK=4 -> grant sequence L,L,L,L,I,L,L,L,L,I; the IFU is never starved more than 4 grants.
- RD_LAT=3, LSU read -> WAIT lasts 3 cycles; lsu_ack 5 cycles after the request; rdata equals the value the model presents on the third WAIT edge.
- rst_n asserted during WAIT -> in that same cycle busy=0, sram_en=0 and no ack; after release, the re-requested read completes normally.
- New request raised in the cycle after ack -> accepted on the next IDLE edge; no duplicate ack is issued for the previous transaction.
